reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 29 ++
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: access bus for the 32 x 32-bit register file.
//   EN     - block enable; gates both read and write
//   read   - load out from the register at selout
//   write  - store inp into the register at selin
//   selin  - write address (0..31)
//   selout - read address (0..31)
//   inp    - write data
//   out    - registered read data (driven by the register file)
// master: the requester (drives commands, receives out).
// slave : the register file.
interface reg_file_if;
    logic        EN;
    logic        read;
    logic        write;
    logic [4:0]  selin;
    logic [4:0]  selout;
    logic [31:0] inp;
    logic [31:0] out;

    modport master (
        output EN, read, write, selin, selout, inp,
        input  out
    );

    modport slave (
        input  EN, read, write, selin, selout, inp,
        output out
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32 independent 32-bit registers with one write port and one
// registered read port, both gated by a block enable.
//   clk   - single clock, all state changes on its rising edge
//   reset - synchronous active-high reset; clears every register and out,
//           overriding EN/read/write in the same cycle
//   bus   - reg_file_if.slave carrying EN, read, write, selin, selout,
//           inp (inputs) and out (registered read data)
// A read and write in the same cycle both take effect; a read of the
// address being written returns the old contents (read-before-write).
module reg_file (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);

    logic [31:0] regs_q [32];
    logic [31:0] out_q;
    logic [31:0] out_d;

    // out only moves on an enabled read; otherwise it holds.
    always_comb begin
        out_d = out_q;
        if (bus.EN && bus.read) begin
            out_d = regs_q[bus.selout];
        end
    end

    // Storage and read register. The read samples regs_q before the
    // non-blocking write lands, which gives the old-data-on-collision
    // behaviour without any bypass logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            out_q <= 32'h0000_0000;
        end else begin
            if (bus.EN && bus.write) begin
                regs_q[bus.selin] <= bus.inp;
            end
            out_q <= out_d;
        end
    end

    // out comes straight from a flop: no combinational input-to-output path.
    assign bus.out = out_q;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rd, input logic wr,
                         input logic [4:0] si, input logic [4:0] so,
                         input logic [31:0] d);
        bus.EN     = en;
        bus.read   = rd;
        bus.write  = wr;
        bus.selin  = si;
        bus.selout = so;
        bus.inp    = d;
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Reset with all commands active to show reset dominates.
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        cyc();
        cyc();
        check("reset_out", bus.out, 32'h0000_0000);

        // Read of unwritten register 0.
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0);
        cyc();
        check("read_r0_init", bus.out, 32'h0000_0000);

        // Write r0; read=0 so out must hold.
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 32'h8000_0001);
        cyc();
        check("hold_read0", bus.out, 32'h0000_0000);

        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0);
        cyc();
        check("read_r0", bus.out, 32'h8000_0001);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 32'h0);
        cyc();
        check("read_r1_init", bus.out, 32'h0000_0000);

        // Write r1 with the same pattern, then alternate reads.
        drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 32'h8000_0001);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd0, 5'(k % 2), 32'h0);
            cyc();
            check((k % 2) ? "alt_r1" : "alt_r0", bus.out, 32'h8000_0001);
        end

        // Park out at 0 so a hold is distinguishable from a read of r0.
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 32'h0);
        cyc();
        check("read_r5_init", bus.out, 32'h0000_0000);

        // EN=0: neither the write nor the read may take effect.
        drive(1'b0, 1'b1, 1'b1, 5'd2, 5'd0, 32'hDEAD_BEEF);
        cyc();
        check("en0_hold_out", bus.out, 32'h0000_0000);
        cyc();
        check("en0_hold_out2", bus.out, 32'h0000_0000);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd2, 32'h0);
        cyc();
        check("en0_no_write", bus.out, 32'h0000_0000);

        // Same-cycle read and write of r3: old data, then new data.
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 32'h1234_5678);
        cyc();
        check("rw_same_old", bus.out, 32'h0000_0000);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 32'h0);
        cyc();
        check("rw_same_new", bus.out, 32'h1234_5678);

        // Same-cycle read and write of different addresses.
        drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 32'h0F0F_F0F0);
        cyc();
        check("rw_diff_read", bus.out, 32'h8000_0001);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd9, 32'h0);
        cyc();
        check("rw_diff_write", bus.out, 32'h0F0F_F0F0);

        // Fill every address with address * 0x01010101, then read back.
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 1'b1, 5'(a), 5'd0, 32'(a) * 32'h0101_0101);
            cyc();
        end
        for (int a = 31; a >= 0; a--) begin
            drive(1'b1, 1'b1, 1'b0, 5'd0, 5'(a), 32'h0);
            cyc();
            check($sformatf("fill_r%0d", a), bus.out, 32'(a) * 32'h0101_0101);
        end

        // Reset with a write pending: the write is discarded.
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd31, 32'hFFFF_FFFF);
        cyc();
        check("rst_mid_out", bus.out, 32'h0000_0000);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd0, 5'(a), 32'h0);
            cyc();
            check($sformatf("post_rst_r%0d", a), bus.out, 32'h0000_0000);
        end

        // Reset, then operate on the very first edge after release.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
        cyc();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 32'hA5A5_A5A5);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd4, 32'h0);
        cyc();
        check("resume_no_idle", bus.out, 32'hA5A5_A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
